// File: rtl/cache_types.sv
// rtl/cache_types.sv - shared state encoding and default geometry for the L1 cache responder
package cache_types;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} cache_state_t;

  localparam int S_INDEX_DEF  = 3;
  localparam int S_OFFSET_DEF = 5;

  function automatic int tag_width(input int s_index, input int s_offset);
    return 32 - s_index - s_offset;
  endfunction

  function automatic int line_width(input int s_offset);
    return 1 << (s_offset + 3);
  endfunction

  localparam int TAG_W  = tag_width(S_INDEX_DEF, S_OFFSET_DEF);
  localparam int LINE_W = line_width(S_OFFSET_DEF);

endpackage

// File: rtl/l1_line_array.sv
// rtl/l1_line_array.sv - per-set storage: async read, sync write with per-byte mask
module l1_line_array #(
  parameter int WIDTH      = 32,
  parameter int IDX_W      = 3,
  parameter bit RESETTABLE = 1'b0,
  parameter int MASK_W     = (WIDTH + 7) / 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_index,
  input  logic [MASK_W-1:0] i_wmask,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [2**IDX_W];

  assign o_rdata = r_mem[i_index];

  generate
    if (RESETTABLE) begin : g_rst
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int s = 0; s < 2**IDX_W; s++) r_mem[s] <= '0;
        end else if (i_we) begin
          for (int b = 0; b < WIDTH; b++)
            if (i_wmask[b/8]) r_mem[i_index][b] <= i_wdata[b];
        end
      end
    end else begin : g_norst
      // Tag and data contents survive reset; only valid/dirty are cleared.
      logic w_unused_rst;
      assign w_unused_rst = i_rst_n;
      always_ff @(posedge i_clk) begin
        if (i_we) begin
          for (int b = 0; b < WIDTH; b++)
            if (i_wmask[b/8]) r_mem[i_index][b] <= i_wdata[b];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/l1_cache_responder.sv
// rtl/l1_cache_responder.sv - direct-mapped write-back L1: zero-stall hits, writeback/fill on miss
module l1_cache_responder
  import cache_types::*;
#(
  parameter int S_INDEX  = S_INDEX_DEF,
  parameter int S_OFFSET = S_OFFSET_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_cmem_read,
  input  logic                         i_cmem_write,
  input  logic [3:0]                   i_cmem_byte_enable,
  input  logic [31:0]                  i_cmem_address,
  input  logic [31:0]                  i_cmem_wdata,
  output logic                         o_cmem_resp,
  output logic [31:0]                  o_cmem_rdata,
  output logic                         o_hit,
  output logic                         o_pmem_read,
  output logic                         o_pmem_write,
  output logic [31:0]                  o_pmem_address,
  output logic [2**(S_OFFSET+3)-1:0]   o_pmem_wdata,
  input  logic [2**(S_OFFSET+3)-1:0]   i_pmem_rdata,
  input  logic                         i_pmem_resp
);

  localparam int TAG_BITS  = tag_width(S_INDEX, S_OFFSET);
  localparam int LINE_BITS = line_width(S_OFFSET);
  localparam int BYTES     = LINE_BITS / 8;
  localparam int WORDS     = LINE_BITS / 32;
  localparam int TAG_MASK  = (TAG_BITS + 7) / 8;

  cache_state_t r_state;
  logic [S_INDEX-1:0]   r_index;
  logic [TAG_BITS-1:0]  r_tag;
  logic                 r_miss;
  logic                 r_pmem_read;
  logic                 r_pmem_write;
  logic [31:0]          r_pmem_addr;

  logic                 w_req;
  logic [S_INDEX-1:0]   w_index;
  logic [S_INDEX-1:0]   w_arr_index;
  logic [TAG_BITS-1:0]  w_tag;
  logic [TAG_BITS-1:0]  w_tag_rd;
  logic [S_OFFSET-3:0]  w_word;
  logic [LINE_BITS-1:0] w_data_rd;
  logic [LINE_BITS-1:0] w_data_wdata;
  logic [BYTES-1:0]     w_data_wmask;
  logic                 w_valid_rd;
  logic                 w_dirty_rd;
  logic                 w_hit;
  logic                 w_hit_wr;
  logic                 w_fill_done;
  logic                 w_dirty_we;
  logic                 w_unused_addr;

  assign w_req         = i_cmem_read | i_cmem_write;
  assign w_tag         = i_cmem_address[31 -: TAG_BITS];
  assign w_index       = i_cmem_address[S_OFFSET +: S_INDEX];
  assign w_word        = i_cmem_address[S_OFFSET-1:2];
  assign w_unused_addr = ^i_cmem_address[1:0];

  // While a miss is outstanding the arrays look at the latched set, so the
  // victim line stays stable even if the cpu misbehaves and moves the address.
  assign w_arr_index = (r_state == IDLE) ? w_index : r_index;

  assign w_hit       = (r_state == IDLE) & w_req & w_valid_rd & (w_tag_rd == w_tag);
  assign w_hit_wr    = w_hit & i_cmem_write;
  assign w_fill_done = (r_state == FILL) & i_pmem_resp;
  assign w_dirty_we  = w_fill_done | (w_hit_wr & (|i_cmem_byte_enable));

  assign w_data_wmask = w_fill_done ? {BYTES{1'b1}}
                      : ({{(BYTES-4){1'b0}}, i_cmem_byte_enable} << {w_word, 2'b00});
  assign w_data_wdata = w_fill_done ? i_pmem_rdata : {WORDS{i_cmem_wdata}};

  l1_line_array #(.WIDTH(LINE_BITS), .IDX_W(S_INDEX), .RESETTABLE(1'b0)) u_data (
    .i_clk(i_clk), .i_rst_n(1'b1), .i_we(w_hit_wr | w_fill_done), .i_index(w_arr_index),
    .i_wmask(w_data_wmask), .i_wdata(w_data_wdata), .o_rdata(w_data_rd));

  l1_line_array #(.WIDTH(TAG_BITS), .IDX_W(S_INDEX), .RESETTABLE(1'b0)) u_tag (
    .i_clk(i_clk), .i_rst_n(1'b1), .i_we(w_fill_done), .i_index(w_arr_index),
    .i_wmask({TAG_MASK{1'b1}}), .i_wdata(r_tag), .o_rdata(w_tag_rd));

  l1_line_array #(.WIDTH(1), .IDX_W(S_INDEX), .RESETTABLE(1'b1)) u_valid (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_we(w_fill_done), .i_index(w_arr_index),
    .i_wmask(1'b1), .i_wdata(1'b1), .o_rdata(w_valid_rd));

  l1_line_array #(.WIDTH(1), .IDX_W(S_INDEX), .RESETTABLE(1'b1)) u_dirty (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_we(w_dirty_we), .i_index(w_arr_index),
    .i_wmask(1'b1), .i_wdata(~w_fill_done), .o_rdata(w_dirty_rd));

  assign o_cmem_resp    = w_hit;
  assign o_cmem_rdata   = w_hit ? w_data_rd[{w_word, 5'b00000} +: 32] : 32'h0;
  assign o_hit          = w_hit & ~r_miss;
  assign o_pmem_read    = r_pmem_read;
  assign o_pmem_write   = r_pmem_write;
  assign o_pmem_address = r_pmem_addr;
  assign o_pmem_wdata   = r_pmem_write ? w_data_rd : {LINE_BITS{1'b0}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_index      <= '0;
      r_tag        <= '0;
      r_miss       <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_pmem_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_hit) begin
            r_index <= w_index;
            r_tag   <= w_tag;
            r_miss  <= 1'b1;
            if (w_valid_rd && w_dirty_rd) begin
              r_state      <= WRITEBACK;
              r_pmem_write <= 1'b1;
              r_pmem_addr  <= {w_tag_rd, w_index, {S_OFFSET{1'b0}}};
            end else begin
              r_state     <= FILL;
              r_pmem_read <= 1'b1;
              r_pmem_addr <= {w_tag, w_index, {S_OFFSET{1'b0}}};
            end
          end else begin
            r_miss <= 1'b0;
          end
        end
        WRITEBACK: begin
          if (i_pmem_resp) begin
            r_state      <= FILL;
            r_pmem_write <= 1'b0;
            r_pmem_read  <= 1'b1;
            r_pmem_addr  <= {r_tag, r_index, {S_OFFSET{1'b0}}};
          end
        end
        FILL: begin
          if (i_pmem_resp) begin
            r_state     <= IDLE;
            r_pmem_read <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_cache_responder.sv
// tb/tb_l1_cache_responder.sv - directed bench with a cache-content model and pmem responder
module tb_l1_cache_responder;

  localparam int LW = cache_types::LINE_W;

  logic          clk;
  logic          rst_n;
  logic          cmem_read;
  logic          cmem_write;
  logic [3:0]    cmem_byte_enable;
  logic [31:0]   cmem_address;
  logic [31:0]   cmem_wdata;
  logic          cmem_resp;
  logic [31:0]   cmem_rdata;
  logic          hit;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  l1_cache_responder dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmem_read(cmem_read), .i_cmem_write(cmem_write),
    .i_cmem_byte_enable(cmem_byte_enable), .i_cmem_address(cmem_address),
    .i_cmem_wdata(cmem_wdata), .o_cmem_resp(cmem_resp), .o_cmem_rdata(cmem_rdata),
    .o_hit(hit), .o_pmem_read(pmem_read), .o_pmem_write(pmem_write),
    .o_pmem_address(pmem_address), .o_pmem_wdata(pmem_wdata),
    .i_pmem_rdata(pmem_rdata), .i_pmem_resp(pmem_resp));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Backing memory behind pmem: written lines are remembered, others follow a pattern.
  logic [31:0] back [logic [31:0]];

  function automatic logic [31:0] back_rd(input logic [31:0] a);
    if (back.exists(a)) return back[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  logic        pen = 1'b1;
  int          pcnt = 0;
  int          n_fill = 0;
  int          n_wb = 0;
  int          last_presp = 0;
  logic [31:0] last_fill_addr = '0;
  logic [31:0] last_wb_addr = '0;
  logic [31:0] last_wb_w1 = '0;

  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pmem_resp = 1'b0;
      pcnt = 0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
    end else if (pen && (pmem_read || pmem_write)) begin
      pcnt++;
      if (pcnt >= 2) begin
        pcnt = 0;
        pmem_resp = 1'b1;
        last_presp = cyc;
        if (pmem_write) begin
          n_wb++;
          last_wb_addr = pmem_address;
          last_wb_w1 = pmem_wdata[63:32];
          for (int w = 0; w < 8; w++) back[pmem_address + 32'(4*w)] = pmem_wdata[w*32 +: 32];
        end else begin
          n_fill++;
          last_fill_addr = pmem_address;
          for (int w = 0; w < 8; w++) pmem_rdata[w*32 +: 32] = back_rd(pmem_address + 32'(4*w));
        end
      end
    end
  end

  // Cache-content model: which line each set holds, its words, dirtiness, and the
  // outstanding pmem transaction (0 none, 1 writeback of victim, 2 fill of request).
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [31:0] m_tag   [8];
  logic [31:0] m_line  [8][8];
  int          m_phase = 0;
  logic        m_miss = 1'b0;
  int          m_ri = 0;
  logic [31:0] m_rt = '0;

  logic          e_resp, e_prd, e_pwr, mreq;
  logic [31:0]   e_paddr, m_tg;
  logic [LW-1:0] e_pw;
  int            m_idx, m_wd;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_cmem_resp", cmem_resp, 0);
      chk("rst_hit", hit, 0);
      chk("rst_pmem_read", pmem_read, 0);
      chk("rst_pmem_write", pmem_write, 0);
      m_phase = 0;
      m_miss = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_valid[i] = 1'b0;
        m_dirty[i] = 1'b0;
      end
    end else begin
      mreq  = cmem_read | cmem_write;
      m_idx = int'((cmem_address >> 5) & 32'h7);
      m_tg  = cmem_address >> 8;
      m_wd  = int'((cmem_address >> 2) & 32'h7);
      e_resp = 1'b0; e_prd = 1'b0; e_pwr = 1'b0; e_paddr = '0; e_pw = '0;
      if (m_phase == 0) begin
        e_resp = mreq && m_valid[m_idx] && (m_tag[m_idx] == m_tg);
      end else if (m_phase == 1) begin
        e_pwr = 1'b1;
        e_paddr = (m_tag[m_ri] << 8) | 32'(m_ri * 32);
        for (int w = 0; w < 8; w++) e_pw[w*32 +: 32] = m_line[m_ri][w];
      end else begin
        e_prd = 1'b1;
        e_paddr = (m_rt << 8) | 32'(m_ri * 32);
      end
      chk("cmem_resp", cmem_resp, e_resp);
      chk("hit", hit, e_resp && !m_miss);
      chk("pmem_read", pmem_read, e_prd);
      chk("pmem_write", pmem_write, e_pwr);
      if (e_resp) chk("cmem_rdata", cmem_rdata, m_line[m_idx][m_wd]);
      if (e_prd || e_pwr) chk("pmem_address", pmem_address, e_paddr);
      if (e_pwr) chk("pmem_wdata", pmem_wdata, e_pw);

      if (m_phase == 0) begin
        if (e_resp && cmem_write) begin
          for (int b = 0; b < 4; b++)
            if (cmem_byte_enable[b]) m_line[m_idx][m_wd][b*8 +: 8] = cmem_wdata[b*8 +: 8];
          if (cmem_byte_enable != 4'b0000) m_dirty[m_idx] = 1'b1;
        end
        if (e_resp || !mreq) m_miss = 1'b0;
        if (mreq && !e_resp) begin
          m_ri = m_idx;
          m_rt = m_tg;
          m_miss = 1'b1;
          m_phase = (m_valid[m_idx] && m_dirty[m_idx]) ? 1 : 2;
        end
      end else if (m_phase == 1) begin
        if (pmem_resp) m_phase = 2;
      end else if (pmem_resp) begin
        for (int w = 0; w < 8; w++) m_line[m_ri][w] = pmem_rdata[w*32 +: 32];
        m_valid[m_ri] = 1'b1;
        m_dirty[m_ri] = 1'b0;
        m_tag[m_ri] = m_rt;
        m_phase = 0;
      end
    end
  end

  int resp_cyc = 0;

  // Called at posedge+1; returns with request dropped at a later posedge+1.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic h, output int stall);
    bit got;
    got = 0;
    stall = 0;
    rdata = '0;
    h = 1'b0;
    cmem_read = rd; cmem_write = wr; cmem_address = addr;
    cmem_byte_enable = be; cmem_wdata = wd;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (cmem_resp) begin
        got = 1;
        rdata = cmem_rdata;
        h = hit;
        resp_cyc = cyc;
        break;
      end
      stall++;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout addr=%0h no cmem_resp within 100 cycles", addr);
    end
    @(posedge clk);
    #1;
    cmem_read = 1'b0; cmem_write = 1'b0; cmem_byte_enable = 4'b0000;
  endtask

  logic [31:0] rd;
  logic        h;
  int          st;
  int          fills0, wbs0;
  bit          seen;

  initial begin
    rst_n = 1'b0;
    cmem_read = 1'b0; cmem_write = 1'b0; cmem_byte_enable = 4'b0000;
    cmem_address = '0; cmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    back[32'h44] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pmem_address", pmem_address, 32'h0);
    chk("reset_cmem_rdata", cmem_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Cold read: one fill at 0x40, response one cycle after pmem_resp, not a hit.
    access(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, rd, h, st);
    chk("cold_fill_addr", last_fill_addr, 32'h40);
    chk("cold_fill_count", n_fill, 1);
    chk("cold_no_wb", n_wb, 0);
    chk("cold_rdata", rd, 32'hDEAD_BEEF);
    chk("cold_hit", h, 0);
    chk("cold_latency", resp_cyc - last_presp, 1);

    access(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, rd, h, st);
    chk("rehit_stall", st, 0);
    chk("rehit_hit", h, 1);
    chk("rehit_rdata", rd, 32'hDEAD_BEEF);
    chk("rehit_no_fill", n_fill, 1);

    access(1'b0, 1'b1, 32'h44, 4'b0011, 32'h1234_5678, rd, h, st);
    chk("wr_stall", st, 0);
    chk("wr_hit", h, 1);
    access(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, rd, h, st);
    chk("merge_rdata", rd, 32'hDEAD_5678);
    chk("merge_stall", st, 0);

    // Conflict miss on a dirty victim: writeback of 0x40 first, then fill of 0x140.
    access(1'b1, 1'b0, 32'h140, 4'h0, 32'h0, rd, h, st);
    chk("evict_wb_count", n_wb, 1);
    chk("evict_wb_addr", last_wb_addr, 32'h40);
    chk("evict_wb_word1", last_wb_w1, 32'hDEAD_5678);
    chk("evict_fill_addr", last_fill_addr, 32'h140);
    chk("evict_rdata", rd, 32'h5A5A_0140);
    chk("evict_latency", resp_cyc - last_presp, 1);
    chk("evict_hit", h, 0);

    // Zero byte-enable write leaves the line clean, so its eviction is silent.
    wbs0 = n_wb;
    access(1'b0, 1'b1, 32'h140, 4'b0000, 32'hFFFF_FFFF, rd, h, st);
    chk("be0_stall", st, 0);
    chk("be0_hit", h, 1);
    access(1'b1, 1'b0, 32'h140, 4'h0, 32'h0, rd, h, st);
    chk("be0_unchanged", rd, 32'h5A5A_0140);
    access(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, rd, h, st);
    chk("be0_no_wb", n_wb, wbs0);
    chk("refill_from_wb", rd, 32'hDEAD_5678);

    // Reset while a fill is outstanding.
    pen = 1'b0;
    fills0 = n_fill;
    cmem_read = 1'b1; cmem_address = 32'h244;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = pmem_read;
    end
    chk("rst_mid_fill_started", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pmem_read_drop", pmem_read, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pen = 1'b1;
    access(1'b1, 1'b0, 32'h244, 4'h0, 32'h0, rd, h, st);
    chk("rst_remiss_fill", n_fill, fills0 + 1);
    chk("rst_remiss_addr", last_fill_addr, 32'h240);
    chk("rst_remiss_hit", h, 0);
    access(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, rd, h, st);
    chk("rst_cleared_other", n_fill, fills0 + 2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
